// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit encodings, serial subtractor FSM states
// and a trit decode helper used by the ternary adder and subtractor.
package ternary_pkg;

    localparam logic [1:0] TRIT_0   = 2'b00;
    localparam logic [1:0] TRIT_1   = 2'b01;
    localparam logic [1:0] TRIT_2   = 2'b10;
    localparam logic [1:0] TRIT_BAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Decode a trit to its numeric value; the illegal code reads as zero.
    function automatic logic [1:0] trit_val(input logic [1:0] t);
        logic [1:0] v;
        case (t)
            TRIT_0:  v = 2'd0;
            TRIT_1:  v = 2'd1;
            TRIT_2:  v = 2'd2;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    function automatic logic trit_is_bad(input logic [1:0] t);
        return (t == TRIT_BAD);
    endfunction

endpackage

// File: rtl/ternary_full_subtractor.sv
// Combinational one-trit ternary subtractor: d = a - b - bin (mod 3), bout on underflow.
module ternary_full_subtractor
    import ternary_pkg::*;
(
    input  logic a1,
    input  logic a0,
    input  logic b1,
    input  logic b0,
    input  logic bin,
    output logic d1,
    output logic d0,
    output logic bout
);

    logic [2:0] sum_s;
    logic [2:0] d_s;

    // Bias by 3 so the difference stays non-negative (range 0..5).
    always_comb begin
        sum_s = 3'd0;
        d_s   = 3'd0;
        bout  = 1'b0;
        sum_s = {1'b0, trit_val({a1, a0})} + 3'd3
              - {1'b0, trit_val({b1, b0})} - {2'b00, bin};
        if (sum_s >= 3'd3) begin
            d_s  = sum_s - 3'd3;
            bout = 1'b0;
        end else begin
            d_s  = sum_s;
            bout = 1'b1;
        end
        d1 = d_s[1];
        d0 = d_s[0];
    end

endmodule

// File: rtl/ternary_serial_subtractor.sv
// Digit-serial N-trit ternary subtractor (A - B), LS trit first, start/busy/done handshake.
// Optional sticky illegal-code flag enabled by defining TSUB_ILLEGAL_CHECK_EN.
module ternary_serial_subtractor
    import ternary_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] diff,
    output logic           borrow
`ifdef TSUB_ILLEGAL_CHECK_EN
    ,
    output logic           illegal
`endif
);

    localparam int W     = 2 * N;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_r;
    state_t           state_s;
    logic [W-1:0]     a_sh_r;
    logic [W-1:0]     b_sh_r;
    logic [W-1:0]     diff_r;
    logic [CNT_W-1:0] cnt_r;
    logic             br_r;
    logic             borrow_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             last_s;
    logic             d1_s;
    logic             d0_s;
    logic             bout_s;

    assign accept_s = start && (state_r != S_RUN);
    assign last_s   = (state_r == S_RUN) && (cnt_r == CNT_LAST);

    ternary_full_subtractor u_fs (
        .a1   (a_sh_r[1]),
        .a0   (a_sh_r[0]),
        .b1   (b_sh_r[1]),
        .b0   (b_sh_r[0]),
        .bin  (br_r),
        .d1   (d1_s),
        .d0   (d0_s),
        .bout (bout_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_s = S_RUN;
                else          state_s = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_s = S_DONE;
                else        state_s = S_RUN;
            end
            S_DONE: begin
                if (accept_s) state_s = S_RUN;
                else          state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Operand capture, trit-serial datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            diff_r   <= '0;
            cnt_r    <= '0;
            br_r     <= 1'b0;
            borrow_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_sh_r <= a;
                b_sh_r <= b;
                br_r   <= 1'b0;
                cnt_r  <= '0;
            end else if (state_r == S_RUN) begin
                a_sh_r <= a_sh_r >> 2;
                b_sh_r <= b_sh_r >> 2;
                // New trit enters at the top so trit 0 lands at the LSB after N shifts.
                diff_r <= (diff_r >> 2) | (W'({d1_s, d0_s}) << (W - 2));
                br_r   <= bout_s;
                cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (last_s) begin
                    borrow_r <= bout_s;
                end else begin
                    borrow_r <= borrow_r;
                end
            end else begin
                a_sh_r <= a_sh_r;
                b_sh_r <= b_sh_r;
                diff_r <= diff_r;
                cnt_r  <= cnt_r;
            end
            busy_r <= (state_s == S_RUN);
            done_r <= (state_s == S_DONE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;

`ifdef TSUB_ILLEGAL_CHECK_EN
    logic illegal_r;

    // Sticky flag for an illegal code in any processed trit of either operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            illegal_r <= 1'b0;
        end else if ((state_r == S_RUN) &&
                     (trit_is_bad(a_sh_r[1:0]) || trit_is_bad(b_sh_r[1:0]))) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal = illegal_r;
`endif

endmodule

// File: tb/tb_ternary_serial_subtractor.sv
// Directed self-checking bench for ternary_serial_subtractor (N=4).
// Covers the illegal flag when TSUB_ILLEGAL_CHECK_EN is defined.
module tb_ternary_serial_subtractor;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   a;
    logic [7:0]   b;
    logic         busy;
    logic         done;
    logic [7:0]   diff;
    logic         borrow;
`ifdef TSUB_ILLEGAL_CHECK_EN
    logic         illegal;
`endif

    int checks;
    int failures;

    ternary_serial_subtractor #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef TSUB_ILLEGAL_CHECK_EN
        ,
        .illegal(illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge with the given operands.
    task automatic kick(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, diff, borrow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b diff=%h borrow=%b want all 0",
                     busy, done, diff, borrow);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    // 2101 - 1012 = 1012, busy for N cycles then done.
    task automatic test_basic();
        kick(8'h91, 8'h46);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy cycle=%0d got busy=%b done=%b want 1 0", i, busy, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got busy=%b done=%b want 0 1", busy, done);
        end
        checks++;
        if (diff !== 8'h46 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got diff=%h borrow=%b want 46 0", diff, borrow);
        end
        tick();
        checks++;
        if (done !== 1'b0 || diff !== 8'h46 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got done=%b diff=%h borrow=%b want 0 46 0", done, diff, borrow);
        end
    endtask

    // 0000 - 0001 wraps to 2222 with borrow.
    task automatic test_borrow();
        kick(8'h00, 8'h01);
        repeat (N) tick();
        checks++;
        if (done !== 1'b1 || diff !== 8'hAA || borrow !== 1'b1) begin
            failures++;
            $display("FAIL borrow_result got done=%b diff=%h borrow=%b want 1 aa 1", done, diff, borrow);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        kick(8'hAA, 8'hAA);
        repeat (N) tick();
        checks++;
        if (done !== 1'b1 || diff !== 8'h00 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first got done=%b diff=%h borrow=%b want 1 00 0", done, diff, borrow);
        end
        kick(8'h01, 8'h00);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, done);
        end
        repeat (N) tick();
        checks++;
        if (done !== 1'b1 || diff !== 8'h01 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got done=%b diff=%h borrow=%b want 1 01 0", done, diff, borrow);
        end
        tick();
    endtask

    // Start during RUN and operand changes after capture must not disturb the result.
    task automatic test_ignore_start();
        kick(8'h91, 8'h46);
        tick();
        a     = 8'h00;
        b     = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'h22;
        b     = 8'h99;
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || diff !== 8'h46 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result got done=%b diff=%h borrow=%b want 1 46 0", done, diff, borrow);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_queue got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        kick(8'h91, 8'h46);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, diff, borrow} !== 11'd0) begin
            failures++;
            $display("FAIL midrst_state got busy=%b done=%b diff=%h borrow=%b want all 0",
                     busy, done, diff, borrow);
        end
        kick(8'h00, 8'h01);
        repeat (N) tick();
        checks++;
        if (done !== 1'b1 || diff !== 8'hAA || borrow !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after got done=%b diff=%h borrow=%b want 1 aa 1", done, diff, borrow);
        end
        tick();
    endtask

`ifdef TSUB_ILLEGAL_CHECK_EN
    task automatic test_illegal();
        kick(8'h03, 8'h00);
        repeat (N) tick();
        checks++;
        if (done !== 1'b1 || illegal !== 1'b1 || diff !== 8'h00 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL illegal_set got done=%b illegal=%b diff=%h borrow=%b want 1 1 00 0",
                     done, illegal, diff, borrow);
        end
        tick();
        kick(8'h01, 8'h00);
        repeat (N) tick();
        checks++;
        if (done !== 1'b1 || illegal !== 1'b0 || diff !== 8'h01) begin
            failures++;
            $display("FAIL illegal_clear got done=%b illegal=%b diff=%h want 1 0 01", done, illegal, diff);
        end
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
`ifdef TSUB_ILLEGAL_CHECK_EN
        test_illegal();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ternary_serial_subtractor.md
Name: ternary_serial_subtractor

Overview:
- Digit-serial N-trit ternary subtractor computing A − B, least-significant trit first, one trit per clock.
- Complements the combinational ternary adder. Shares its trit encoding: 2'b00=0, 2'b01=1, 2'b10=2, 2'b11=illegal.
- Used by datapath blocks that need ternary difference and compare (borrow-out = A<B) without a wide combinational array.
- Start/busy/done handshake to the controlling FSM.

Parameters:
- N, 4, number of trits per operand. Range 1..16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request an operation; sampled only when busy=0.
- a  input  2N  minuend, trit i in bits [2i+1:2i]; trit 0 is least significant.
- b  input  2N  subtrahend, same layout.
- busy  output  1  high while trits are being processed.
- done  output  1  one-cycle pulse; diff and borrow valid from this cycle.
- diff  output  2N  (A − B) mod 3^N, same trit layout.
- borrow  output  1  final borrow-out; 1 iff A < B.

Behaviour:
- Reset is synchronous only: rst_n=0 at a rising edge forces the following, regardless of state:
  - state=IDLE
  - busy=0, done=0, diff=0, borrow=0
  - internal operand shift registers, trit counter and borrow register = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge captures a and b into shift registers.
  - Clears the internal borrow and the counter, then goes to RUN with busy=1.
- RUN:
  - Each edge processes trit k: d = a_k − b_k − br.
  - If d<0: d+=3, br=1; else br=0.
  - d is shifted into the diff register from the MSB end; counter increments.
  - After the N-th edge: go to DONE, busy=0, done=1, borrow=br.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operations.
- Latency: start sampled at edge t, done high in the cycle after edge t+N. Throughput: one op per N+1 cycles.
- diff and borrow hold their values from done until the next accepted start. They may show partial results while busy=1.
- start while busy=1 is ignored. a and b may change freely after capture.
- Illegal code 11 in a processed trit is treated as value 0 (default build).
- N=1: RUN lasts one cycle.

Optional Feature:
- Macro TSUB_ILLEGAL_CHECK_EN.
- Defined:
  - Adds output illegal (1 bit).
  - Cleared on accepted start and on reset.
  - Set sticky if any processed trit of a or b equals 2'b11; valid with done.
  - diff/borrow computed as in the default build.
- Undefined: no illegal port; no check logic.

Decomposition:
- Package ternary_pkg holds:
  - trit encodings TRIT_0, TRIT_1, TRIT_2, TRIT_BAD
  - FSM state encodings S_IDLE, S_RUN, S_DONE
  - shared with the ternary adder
- Sub-module ternary_full_subtractor (combinational):
  - inputs a1,a0,b1,b0,bin
  - outputs d1,d0,bout
  - one instance used in RUN

Test Plan:
- N=4, a=8'h91 (2101₃=64), b=8'h46 (1012₃=32), start one cycle -> busy for 4 cycles, done 5th cycle after start edge, diff=8'h46 (1012₃), borrow=0.
- a=8'h00, b=8'h01 -> diff=8'hAA (2222₃), borrow=1.
- a=b=8'hAA -> diff=8'h00, borrow=0. Start asserted during DONE with a=8'h01, b=8'h00 -> second result diff=8'h01, borrow=0, no idle gap.
- start pulsed again at cycle 2 of RUN with different operands -> ignored, first result unchanged. a/b changed mid-RUN -> no effect on result.
- rst_n=0 for one edge at cycle 2 of RUN -> next cycle busy=0, done=0, diff=0, borrow=0. A subsequent start yields a correct result.
- With TSUB_ILLEGAL_CHECK_EN: a=8'h03, b=8'h00 -> illegal=1 at done; next op a=8'h01 -> illegal=0.
